// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and the hazard unit that tracks it.
package seq_divider_pkg;

  // FSM encoding
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFixup = 2'b10
  } state_e;

  // Cycles from the acceptance edge to the cycle in which done is high.
  function automatic int unsigned div_lat(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts the dividend MSB into the partial remainder and tries to subtract the divisor.
// The subtract is an add of the inverted divisor with carry-in 1; carry-out 1 means no borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sum;
  logic             w_unused_bit;

  // Trial subtraction; the partial remainder is always below the divisor, so a
  // successful trial fits back into WIDTH bits and bit WIDTH of the sum is spare.
  always_comb begin
    w_shift      = {i_rem, i_dvd_msb};
    w_sum        = {1'b0, w_shift} + {1'b0, ~{1'b0, i_divisor}} + (WIDTH + 2)'(1);
    o_qbit       = w_sum[WIDTH+1];
    o_rem        = o_qbit ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_unused_bit = w_sum[WIDTH];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// One subtract-and-shift per cycle, fixed latency of WIDTH+2 cycles from acceptance to done.
// Optional feature: define SEQDIV_ABORT_EN to add the 'abort' input used by pipeline flushes.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_d;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_dz_pend;
  logic               r_done;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_remd;
  logic               r_dz;

  logic               w_abort;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;

`ifdef SEQDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_dvd_msb(r_dvd[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_next),
    .o_qbit   (w_qbit)
  );

  // Operand magnitudes and acceptance qualifier
  always_comb begin
    w_a_mag  = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    w_b_mag  = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    w_accept = (r_state == StIdle) && start && !w_abort;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; abort overrides every transition including acceptance
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (r_cnt == '0) w_state_d = StFixup;
      StFixup: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_abort) w_state_d = StIdle;
  end

  // FSM outputs
  always_comb begin
    busy      = (r_state != StIdle);
    done      = r_done;
    quotient  = r_quot;
    remainder = r_remd;
    div_zero  = r_dz;
  end

  // Iteration datapath: operand capture on acceptance, one shift/subtract per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_a_raw   <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dz_pend <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CntW'(WIDTH - 1);
      r_rem     <= '0;
      r_dvd     <= w_a_mag;
      r_divisor <= w_b_mag;
      r_a_raw   <= a;
      r_q_neg   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_r_neg   <= signed_op && a[WIDTH-1];
      r_dz_pend <= (b == '0);
    end else if (r_state == StRun) begin
      r_cnt <= r_cnt - CntW'(1);
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
    end
  end

  // Result registers: sign fixup and load in FIXUP; held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_quot <= '0;
      r_remd <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= (r_state == StFixup) && !w_abort;
      if ((r_state == StFixup) && !w_abort) begin
        if (r_dz_pend) begin
          // Divide by zero reports all-ones and the untouched dividend
          r_quot <= '1;
          r_remd <= r_a_raw;
        end else begin
          r_quot <= r_q_neg ? (~r_dvd + WIDTH'(1)) : r_dvd;
          r_remd <= r_r_neg ? (~r_rem + WIDTH'(1)) : r_rem;
        end
        r_dz <= r_dz_pend;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=32). Covers the abort port when SEQDIV_ABORT_EN is set.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          LAT = 34;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SEQDIV_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .signed_op(signed_op),
    .a        (a),
    .b        (b),
`ifdef SEQDIV_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; returns in cycle E+1 with inputs scrambled.
  task automatic launch(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    signed_op = s;
    a         = av;
    b         = bv;
    start     = 1'b1;
    step();
    start     = 1'b0;
    signed_op = ~s;
    a         = 32'hDEAD_BEEF;
    b         = 32'h0000_0005;
  endtask

  // From cycle E+1: busy must be high and done low through E+LAT-1, then done in E+LAT.
  task automatic run_to_done(input string name, input int ignored_at);
    bit bad_window = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      if (c == ignored_at) begin
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1 || done !== 1'b0) bad_window = 1'b1;
      step();
    end
    start = 1'b0;
    checks++;
    if (bad_window) begin
      errors++;
      $display("FAIL %s busy_window: busy/done deviated within cycles E+1..E+%0d", name, LAT - 1);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_at_E+%0d: done=%b busy=%b, required done=1 busy=0",
               name, LAT, done, busy);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic edz);
    checks++;
    if (quotient !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %h, required %h", name, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++;
      $display("FAIL %s remainder: got %h, required %h", name, remainder, er);
    end
    checks++;
    if (div_zero !== edz) begin
      errors++;
      $display("FAIL %s div_zero: got %b, required %b", name, div_zero, edz);
    end
  endtask

  task automatic divide(input string name, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz);
    launch(s, av, bv);
    run_to_done(name, 0);
    check_result(name, eq, er, edz);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SEQDIV_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset busy_done: got busy=%b done=%b, required 0 0", busy, done);
    end
    check_result("reset", 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_unsigned();
    divide("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    // Outputs must hold and done must drop in IDLE
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL divu_hold done: got %b, required 0", done);
    end
    check_result("divu_hold", 32'd14, 32'd2, 1'b0);
    divide("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
    step();
  endtask

  task automatic test_signed();
    divide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    step();
    divide("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    step();
    divide("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    step();
    // Same bit pattern unsigned: 0xFFFFFFF9 / 2
    divide("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    step();
  endtask

  task automatic test_div_zero();
    divide("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    step();
    divide("div_zero", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    step();
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 32'd20, 32'd6);
    run_to_done("b2b_first", 5);
    check_result("b2b_first", 32'd3, 32'd2, 1'b0);
    // New request in the done cycle
    launch(1'b0, 32'd9, 32'd3);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    run_to_done("b2b_second", 0);
    check_result("b2b_second", 32'd3, 32'd0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    launch(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy_done: got busy=%b done=%b, required 0 0", busy, done);
    end
    check_result("reset_mid", 32'd0, 32'd0, 1'b0);
    step();
    reset = 1'b1;
    step();
  endtask

`ifdef SEQDIV_ABORT_EN
  task automatic test_abort();
    bit saw_done = 1'b0;
    divide("abort_pre", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    step();
    launch(1'b1, 32'd50, 32'd5);
    for (int i = 0; i < 9; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort busy: got %b, required 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort no_done: got done pulse, required none");
    end
    check_result("abort_hold", 32'd14, 32'd2, 1'b0);
    // Abort together with start: start is dropped
    signed_op = 1'b0;
    a         = 32'd8;
    b         = 32'd2;
    start     = 1'b1;
    abort     = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start busy: got %b, required 0", busy);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQDIV_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
